rr_arbiter_4_v: RTL and testbench

//  - 4-requester round-robin arbiter with grant hold and starvation timeout.
//  - Shares one resource (e.g. a bus or datapath slot) among 4 requesters.
//  - Request selection uses a 4:2 priority pick on requests rotated by a pointer.
//  - Publishes one-hot grant, 2-bit grant code and valid, in the same style as the 4:2 priority encoder.

---
 rtl/rr_arbiter_4_v_pkg.sv | 17 +
 rtl/rr_arbiter_4_v_if.sv | 22 ++
 rtl/rr_arbiter_4_v_pick.sv | 31 +++
 rtl/rr_arbiter_4_v.sv | 112 +++++++++++
 tb/tb_rr_arbiter_4_v.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_4_v_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
// Holds the FSM state encoding and the code-to-one-hot helper.
package rr_arbiter_4_v_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic logic [N_REQ-1:0] code_to_onehot(input logic [1:0] code);
    return N_REQ'(1) << code;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_v_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_4_v_if;
  import rr_arbiter_4_v_pkg::*;

  logic             i_en;
  logic [N_REQ-1:0] i_req;
  logic [N_REQ-1:0] o_gnt;
  logic [1:0]       o_gnt_code;
  logic             o_valid;
  logic             o_timeout;

  modport master (
    output i_en, i_req,
    input  o_gnt, o_gnt_code, o_valid, o_timeout
  );

  modport slave (
    input  i_en, i_req,
    output o_gnt, o_gnt_code, o_valid, o_timeout
  );

endinterface

// File: rtl/rr_arbiter_4_v_pick.sv
// Rotating priority pick: first asserted request at or after ptr, wrapping 3->0.
// Purely combinational; the caller registers the result.
module rr_arbiter_4_v_pick
  import rr_arbiter_4_v_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       code,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [1:0]       pick;

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path, or a latch is inferred.
    rot  = '0;
    pick = 2'd0;
    // Rotate right by ptr so the line at the pointer lands at position 0.
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[2'(i) + ptr];
    end
    if      (rot[0]) pick = 2'd0;
    else if (rot[1]) pick = 2'd1;
    else if (rot[2]) pick = 2'd2;
    else if (rot[3]) pick = 2'd3;
    code = pick + ptr;
    any  = |req;
  end

endmodule

// File: rtl/rr_arbiter_4_v.sv
// 4-requester round-robin arbiter with grant hold, one-cycle release gap and
// starvation timeout. All outputs are registered.
module rr_arbiter_4_v
  import rr_arbiter_4_v_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  rr_arbiter_4_v_if.slave bus
);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic [1:0]       pick_code;
  logic             pick_any;
  logic             owner_req;

  rr_arbiter_4_v_pick u_pick (
    .req  (bus.i_req),
    .ptr  (ptr_q),
    .code (pick_code),
    .any  (pick_any)
  );

  assign owner_req = bus.i_req[code_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    code_d    = code_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;

    case (state_q)
      // GAP is the dead cycle after a release; it arbitrates exactly like IDLE.
      ST_IDLE, ST_GAP: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        code_d  = 2'd0;
        valid_d = 1'b0;
        cnt_d   = '0;
        if (bus.i_en && pick_any) begin
          state_d = ST_BUSY;
          gnt_d   = code_to_onehot(pick_code);
          code_d  = pick_code;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end

      ST_BUSY: begin
        if (!owner_req || cnt_q == CNT_W'(MAX_HOLD)) begin
          state_d   = ST_GAP;
          gnt_d     = '0;
          code_d    = 2'd0;
          valid_d   = 1'b0;
          cnt_d     = '0;
          ptr_d     = code_q + 2'd1;
          // A voluntary release in the same cycle takes precedence over the timeout flag.
          timeout_d = owner_req;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        code_d  = 2'd0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      code_q    <= 2'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_gnt      = gnt_q;
  assign bus.o_gnt_code = code_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_timeout  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4_v.sv
// Self-checking bench for rr_arbiter_4_v: directed scenarios plus randomized
// traffic, compared cycle by cycle against a behavioural owner/pointer model.
module tb_rr_arbiter_4_v;

  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst_n;

  rr_arbiter_4_v_if bus ();

  rr_arbiter_4_v #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: who owns the resource, for how long, and where the pointer sits.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  bit m_to    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic [3:0] q);
    m_to = 1'b0;
    if (!r) begin
      m_owner = -1; m_held = 0; m_ptr = 0;
    end else if (m_owner >= 0) begin
      if (!q[m_owner] || m_held == MAX_HOLD) begin
        m_to    = q[m_owner];
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_held  = 0;
      end else begin
        m_held++;
      end
    end else if (e && q != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && q[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_held  = 1;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1ns later.
  task automatic cycle(input logic r, input logic e, input logic [3:0] q);
    logic [3:0] exp_gnt;
    rst_n     = r;
    bus.i_en  = e;
    bus.i_req = q;
    @(posedge clk);
    model_step(r, e, q);
    #1;
    exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check("gnt",      32'(bus.o_gnt),      32'(exp_gnt));
    check("code",     32'(bus.o_gnt_code), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("valid",    32'(bus.o_valid),    32'(m_owner >= 0));
    check("timeout",  32'(bus.o_timeout),  32'(m_to));
    check("onehot0",  32'($onehot0(bus.o_gnt)), 32'd1);
    check("valid_or", 32'(bus.o_valid),    32'(|bus.o_gnt));
  endtask

  initial begin
    int seq[$];
    logic [3:0] r;
    logic prev_valid;

    rst_n = 1'b0; bus.i_en = 1'b0; bus.i_req = 4'b0000;

    // 1 Reset with all requests high, then release with enable.
    cycle(1'b0, 1'b1, 4'b1111);
    check("t1_rst_gnt", 32'(bus.o_gnt), 32'd0);
    cycle(1'b1, 1'b1, 4'b1111);
    check("t1_first_gnt", 32'(bus.o_gnt), 32'b0001);

    // 2 Rotation: every owner drops after 2 cycles then re-raises.
    cycle(1'b0, 1'b1, 4'b0000);
    prev_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
      cycle(1'b1, 1'b1, r);
      if (bus.o_valid && !prev_valid) seq.push_back(int'(bus.o_gnt_code));
      prev_valid = bus.o_valid;
    end
    check("t2_ngrants", (seq.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 5 && i < seq.size(); i++) check("t2_order", 32'(seq[i]), 32'(i % 4));

    // 3 Timeout on a continuously requesting line 2.
    cycle(1'b0, 1'b1, 4'b0000);
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 1'b1, 4'b0100);
      if (i <= 8) check("t3_hold", 32'(bus.o_gnt), 32'b0100);
      if (i == 9) begin
        check("t3_to", 32'(bus.o_timeout), 32'd1);
        check("t3_gap", 32'(bus.o_gnt), 32'd0);
      end
      if (i == 10) check("t3_regrant", 32'(bus.o_gnt), 32'b0100);
    end

    // 4 Pointer wrap after owner 3 releases.
    cycle(1'b0, 1'b1, 4'b0000);
    cycle(1'b1, 1'b1, 4'b1000);
    check("t4_own3", 32'(bus.o_gnt_code), 32'd3);
    cycle(1'b1, 1'b1, 4'b1000);
    cycle(1'b1, 1'b1, 4'b0011);
    cycle(1'b1, 1'b1, 4'b0011);
    check("t4_wrap", 32'(bus.o_gnt), 32'b0001);

    // 5 Enable gating and enable drop during a grant.
    cycle(1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'b0010);
    check("t5_gated", 32'(bus.o_valid), 32'd0);
    cycle(1'b1, 1'b1, 4'b0010);
    check("t5_grant", 32'(bus.o_gnt), 32'b0010);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'b0010);
    check("t5_held", 32'(bus.o_gnt), 32'b0010);
    cycle(1'b1, 1'b0, 4'b0000);
    check("t5_release", 32'(bus.o_valid), 32'd0);

    // 6 Mid-grant reset pulse.
    cycle(1'b0, 1'b1, 4'b0000);
    cycle(1'b1, 1'b1, 4'b0010);
    cycle(1'b1, 1'b1, 4'b0010);
    check("t6_busy", 32'(bus.o_gnt), 32'b0010);
    cycle(1'b0, 1'b1, 4'b1111);
    check("t6_rst_gnt", 32'(bus.o_gnt), 32'd0);
    check("t6_rst_to", 32'(bus.o_timeout), 32'd0);
    cycle(1'b1, 1'b1, 4'b1111);
    check("t6_from0", 32'(bus.o_gnt), 32'b0001);

    // Randomized traffic; owners usually keep requesting so timeouts occur.
    for (int i = 0; i < 3000; i++) begin
      r = 4'($urandom);
      if (m_owner >= 0 && ($urandom % 8) != 0) r[m_owner] = 1'b1;
      cycle(($urandom % 128) != 0, ($urandom % 4) != 0, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
